// File: rtl/activation_output_packer.sv
// Packs PACK_FACTOR activated features into one wide word and queues words in a small FIFO
// behind a valid/ready port. Optional statistics counters are enabled by ACT_PACKER_STATS_EN.
module activation_output_packer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PACK_FACTOR = 4,
  parameter int unsigned FIFO_DEPTH  = 8
`ifdef ACT_PACKER_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH   = 16
`endif
) (
  input  logic                                core_clk,
  input  logic                                reset,
  input  logic                                activated_feature_valid,
  input  logic [DATA_WIDTH-1:0]               activated_feature,
  input  logic                                flush,
  output logic                                packed_valid,
  input  logic                                packed_ready,
  output logic [DATA_WIDTH*PACK_FACTOR-1:0]   packed_data,
  output logic [$clog2(PACK_FACTOR+1)-1:0]    packed_count,
  output logic                                packed_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                overflow,
  output logic                                busy
`ifdef ACT_PACKER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]                stat_words_out,
  output logic [CNT_WIDTH-1:0]                stat_features_dropped
`endif
);

  localparam int unsigned IdxW = $clog2(PACK_FACTOR);
  localparam int unsigned CntW = $clog2(PACK_FACTOR+1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [PACK_FACTOR-1:0][DATA_WIDTH-1:0] data;
    logic [CntW-1:0]                        count;
    logic                                   last;
  } word_t;

  logic [IdxW-1:0]                        idx_q, idx_d;
  logic [PACK_FACTOR-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d, lanes_fill;
  logic [PtrW-1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]                        level_q, level_d;
  logic                                   overflow_q, overflow_d;
  word_t                                  mem_q [FIFO_DEPTH];
  word_t                                  mem_d [FIFO_DEPTH];
  word_t                                  push_word, head;
  logic                                   close, pop, full, push, drop;

  always_comb begin
    lanes_fill = lanes_q;
    if (activated_feature_valid) lanes_fill[idx_q] = activated_feature;

    // A word closes when its last lane fills or a flush finds anything to send.
    close = (activated_feature_valid && (idx_q == IdxW'(PACK_FACTOR-1))) ||
            (flush && ((idx_q != '0) || activated_feature_valid));

    push_word.data  = lanes_fill;
    push_word.count = CntW'(idx_q) + CntW'(activated_feature_valid);
    push_word.last  = flush;

    pop  = (level_q != '0) && packed_ready;
    full = (level_q == LvlW'(FIFO_DEPTH));
    push = close && (!full || pop);
    drop = close && full && !pop;

    idx_d      = close ? '0 : idx_q + IdxW'(activated_feature_valid);
    lanes_d    = close ? '0 : lanes_fill;
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    level_d    = level_q + LvlW'(push) - LvlW'(pop);
    overflow_d = overflow_q || drop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_word;
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      idx_q      <= '0;
      lanes_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      lanes_q    <= lanes_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge core_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    packed_valid = (level_q != '0);
    packed_data  = packed_valid ? head.data : '0;
    packed_count = packed_valid ? head.count : '0;
    packed_last  = packed_valid && head.last;
    fifo_level   = level_q;
    overflow     = overflow_q;
    busy         = (idx_q != '0) || (level_q != '0);
  end

`ifdef ACT_PACKER_STATS_EN
  logic [CNT_WIDTH-1:0] words_out_q, words_out_d;
  logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

  always_comb begin
    words_out_d = words_out_q + CNT_WIDTH'(pop);
    dropped_d   = dropped_q + (drop ? CNT_WIDTH'(push_word.count) : '0);
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      words_out_q <= '0;
      dropped_q   <= '0;
    end else begin
      words_out_q <= words_out_d;
      dropped_q   <= dropped_d;
    end
  end

  assign stat_words_out        = words_out_q;
  assign stat_features_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_activation_output_packer.sv
// Self-checking bench for activation_output_packer: queue-based reference model checked every
// cycle, plus hand-computed expectations from the directed scenarios.
module tb_activation_output_packer;

  logic         core_clk = 1'b0;
  logic         reset = 1'b1;
  logic         activated_feature_valid = 1'b0;
  logic [31:0]  activated_feature = '0;
  logic         flush = 1'b0;
  logic         packed_valid;
  logic         packed_ready = 1'b1;
  logic [127:0] packed_data;
  logic [2:0]   packed_count;
  logic         packed_last;
  logic [3:0]   fifo_level;
  logic         overflow;
  logic         busy;
`ifdef ACT_PACKER_STATS_EN
  logic [15:0]  stat_words_out;
  logic [15:0]  stat_features_dropped;
`endif

  int tests = 0;
  int fails = 0;

  activation_output_packer #(
    .DATA_WIDTH (32),
    .PACK_FACTOR(4),
    .FIFO_DEPTH (8)
  ) dut (
    .core_clk               (core_clk),
    .reset                  (reset),
    .activated_feature_valid(activated_feature_valid),
    .activated_feature      (activated_feature),
    .flush                  (flush),
    .packed_valid           (packed_valid),
    .packed_ready           (packed_ready),
    .packed_data            (packed_data),
    .packed_count           (packed_count),
    .packed_last            (packed_last),
    .fifo_level             (fifo_level),
    .overflow               (overflow),
    .busy                   (busy)
`ifdef ACT_PACKER_STATS_EN
    ,
    .stat_words_out         (stat_words_out),
    .stat_features_dropped  (stat_features_dropped)
`endif
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: features collect in a list, closed words go into a bounded queue.
  typedef struct {
    logic [127:0] data;
    int           count;
    logic         last;
  } mword_t;

  mword_t      mq[$];
  logic [31:0] pend[$];
  logic        m_overflow = 1'b0;
  int          m_words_out = 0;
  int          m_dropped = 0;

  initial forever begin
    @(posedge core_clk);
    if (reset) begin
      mq.delete();
      pend.delete();
      m_overflow  = 1'b0;
      m_words_out = 0;
      m_dropped   = 0;
    end else begin
      bit     do_pop;
      bit     closed;
      mword_t w;
      do_pop = (mq.size() > 0) && packed_ready;
      closed = 1'b0;
      if (activated_feature_valid) pend.push_back(activated_feature);
      if (pend.size() == 4 || (flush && pend.size() > 0)) begin
        w.data = '0;
        foreach (pend[k]) w.data[k*32 +: 32] = pend[k];
        w.count = pend.size();
        w.last  = flush;
        pend.delete();
        closed = 1'b1;
      end
      if (do_pop) begin
        void'(mq.pop_front());
        m_words_out++;
      end
      if (closed) begin
        if (mq.size() < 8) mq.push_back(w);
        else begin
          m_overflow = 1'b1;
          m_dropped += w.count;
        end
      end
    end
  end

  initial forever begin
    @(negedge core_clk);
    chk("m_valid", packed_valid, mq.size() != 0);
    chk("m_level", fifo_level, mq.size());
    chk("m_overflow", overflow, m_overflow);
    chk("m_busy", busy, (pend.size() != 0) || (mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_data", packed_data, mq[0].data);
      chk("m_count", packed_count, mq[0].count);
      chk("m_last", packed_last, mq[0].last);
    end
`ifdef ACT_PACKER_STATS_EN
    chk("m_stat_words", stat_words_out, m_words_out);
    chk("m_stat_dropped", stat_features_dropped, m_dropped);
`endif
  end

  task automatic step(input logic v, input logic [31:0] d, input logic f, input logic r);
    activated_feature_valid = v;
    activated_feature       = d;
    flush                   = f;
    packed_ready            = r;
    @(negedge core_clk);
  endtask

  task automatic do_reset();
    reset                   = 1'b1;
    activated_feature_valid = 1'b0;
    flush                   = 1'b0;
    @(negedge core_clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", packed_valid, 0);
    chk("rst_data", packed_data, 0);
    chk("rst_count", packed_count, 0);
    chk("rst_last", packed_last, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);

    // Full word, consumer ready.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 1'b1);
    chk("t1_valid", packed_valid, 1);
    chk("t1_data", packed_data, 128'h00000004_00000003_00000002_00000001);
    chk("t1_count", packed_count, 4);
    chk("t1_last", packed_last, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("t1_level", fifo_level, 0);

    // Partial word closed by flush.
    step(1'b1, 32'hA, 1'b0, 1'b1);
    step(1'b1, 32'hB, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("t2_data", packed_data, 128'h00000000_00000000_0000000B_0000000A);
    chk("t2_count", packed_count, 2);
    chk("t2_last", packed_last, 1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Flush coincident with the fourth feature yields exactly one word.
    for (int i = 1; i <= 3; i++) step(1'b1, 32'(i + 16), 1'b0, 1'b1);
    step(1'b1, 32'h14, 1'b1, 1'b1);
    chk("t3_count", packed_count, 4);
    chk("t3_last", packed_last, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("t3_no_empty", packed_valid, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("t3_level", fifo_level, 0);

    // Overflow: nine words with the consumer stalled, then drain in order.
    do_reset();
    for (int i = 1; i <= 36; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("t4_level", fifo_level, 8);
    chk("t4_overflow", overflow, 1);
    chk("t4_head", packed_data, 128'h00000004_00000003_00000002_00000001);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b0, 1'b1);
    chk("t4_drained", fifo_level, 0);
    chk("t4_sticky", overflow, 1);
`ifdef ACT_PACKER_STATS_EN
    chk("t4_stat_words", stat_words_out, 8);
    chk("t4_stat_dropped", stat_features_dropped, 4);
`endif

    // Push coinciding with pop while full is accepted.
    do_reset();
    for (int i = 1; i <= 35; i++) step(1'b1, 32'(i + 200), 1'b0, 1'b0);
    step(1'b1, 32'd236, 1'b0, 1'b1);
    chk("t6_level", fifo_level, 8);
    chk("t6_overflow", overflow, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b0, 1'b1);
    chk("t6_drained", fifo_level, 0);

    // Reset mid-word discards partial lanes.
    step(1'b1, 32'd1, 1'b0, 1'b0);
    step(1'b1, 32'd2, 1'b0, 1'b0);
    do_reset();
    chk("t5_busy_rst", busy, 0);
    for (int i = 5; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    chk("t5_level", fifo_level, 1);
    chk("t5_data", packed_data, 128'h00000008_00000007_00000006_00000005);
    chk("t5_count", packed_count, 4);
    chk("t5_overflow", overflow, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("t5_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
